// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Operands are widened by one bit so signed and unsigned modes share one signed loop.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [E-1:0]  a;
    logic [E-1:0]  q;
    logic          q_1;
    logic [E-1:0]  m;
    logic [CW-1:0] count;

    logic [E-1:0]  m_ext;
    logic [E-1:0]  q_ext;
    logic [E-1:0]  a_sum;

    assign m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

    // Booth recoding of the current bit pair; the add/sub wraps modulo 2^E.
    always_comb begin
        a_sum = a;
        case ({q[0], q_1})
            2'b10:   a_sum = a - m;
            2'b01:   a_sum = a + m;
            default: a_sum = a;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (count == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // {A,Q,Q_1} shifts right arithmetically after each step; product only moves in FINISH.
    always_ff @(posedge clk) begin
        if (reset) begin
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m     <= m_ext;
                        q     <= q_ext;
                        a     <= '0;
                        q_1   <= 1'b0;
                        count <= CW'(E);
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a     <= {a_sum[E-1], a_sum[E-1:1]};
                    q     <= {a_sum[0], q[E-1:1]};
                    q_1   <= q[0];
                    count <= count - CW'(1);
                end
                FINISH: begin
                    product <= {a[WIDTH-2:0], q};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH=8 and WIDTH=4,
// with an arithmetic reference model feeding a scoreboard queue.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic reset;

    logic        start8, sm8;
    logic [7:0]  m8, q8;
    logic        busy8, done8;
    logic [15:0] p8;

    logic        start4, sm4;
    logic [3:0]  m4, q4;
    logic        busy4, done4;
    logic [7:0]  p4;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .multiplicand(m8), .multiplier(q8),
        .busy(busy8), .done(done8), .product(p8)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
        .multiplicand(m4), .multiplier(q4),
        .busy(busy4), .done(done4), .product(p4)
    );

    function automatic logic [63:0] model(input logic sm, input int w,
                                          input logic [31:0] m, input logic [31:0] q);
        longint mask, a, b, prod;
        mask = (longint'(1) << w) - 1;
        a = longint'(m) & mask;
        b = longint'(q) & mask;
        if (sm && (((a >> (w - 1)) & 1) == 1)) a = a - (longint'(1) << w);
        if (sm && (((b >> (w - 1)) & 1) == 1)) b = b - (longint'(1) << w);
        prod = a * b;
        return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Launches one operation, scrambles inputs after acceptance, waits for done.
    task automatic run_op(input int w, input logic sm, input logic [31:0] m,
                          input logic [31:0] q, output int lat,
                          output int busy_cycles, output logic [63:0] p);
        @(negedge clk);
        if (w == 8) begin
            sm8 = sm; m8 = m[7:0]; q8 = q[7:0]; start8 = 1'b1;
        end else begin
            sm4 = sm; m4 = m[3:0]; q4 = q[3:0]; start4 = 1'b1;
        end
        exp_q.push_back(model(sm, w, m, q));
        @(posedge clk); #1;
        start8 = 1'b0; start4 = 1'b0;
        sm8 = ~sm8; m8 = 8'($urandom); q8 = 8'($urandom);
        sm4 = ~sm4; m4 = 4'($urandom); q4 = 4'($urandom);
        busy_cycles = ((w == 8) ? busy8 : busy4) ? 1 : 0;
        lat = -1;
        p = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if ((w == 8) ? done8 : done4) begin
                lat = i;
                p = (w == 8) ? 64'(p8) : 64'(p4);
                break;
            end
            if ((w == 8) ? busy8 : busy4) busy_cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start8 = 1'b0; start4 = 1'b0;
        sm8 = 1'b0; m8 = '0; q8 = '0;
        sm4 = 1'b0; m4 = '0; q4 = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy8, done8, p8} !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset8: busy=%b done=%b product=%h, required 0 0 0000", busy8, done8, p8);
        end
        tests_run++;
        if ({busy4, done4, p4} !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset4: busy=%b done=%b product=%h, required 0 0 00", busy4, done4, p4);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_signed_basic;
        int lat, bc;
        logic [63:0] p, e;
        run_op(8, 1'b1, 32'hFD, 32'h05, lat, bc, p);
        e = exp_q.pop_front();
        tests_run++;
        if (lat != 10) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: got %0d edges, required 10", lat);
        end
        tests_run++;
        if (p !== e) begin
            tests_failed++;
            $display("[TB] FAIL basic_product: got %h, required %h", p, e);
        end
        tests_run++;
        if (bc != 10) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy: busy high %0d cycles, required 10", bc);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done8 !== 1'b0 || p8 !== e[15:0]) begin
            tests_failed++;
            $display("[TB] FAIL done_pulse: done=%b product=%h, required 0 %h", done8, p8, e[15:0]);
        end
    endtask

    task automatic test_corners;
        logic [31:0] ops [8][3];
        int lat, bc;
        logic [63:0] p, e;
        ops = '{'{1, 32'h80, 32'h80}, '{0, 32'h80, 32'h80},
                '{0, 32'hFF, 32'hFF}, '{1, 32'hFF, 32'hFF},
                '{1, 32'h7F, 32'h80}, '{0, 32'h00, 32'hFF},
                '{1, 32'h7F, 32'h7F}, '{1, 32'h01, 32'h80}};
        for (int i = 0; i < 8; i++) begin
            run_op(8, ops[i][0][0], ops[i][1], ops[i][2], lat, bc, p);
            e = exp_q.pop_front();
            tests_run++;
            if (p !== e || lat != 10) begin
                tests_failed++;
                $display("[TB] FAIL corner%0d: product=%h lat=%0d, required %h lat=10", i, p, lat, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc, extra_done;
        logic [63:0] p, e1, e2;
        logic held;
        run_op(8, 1'b1, 32'h07, 32'h06, lat, bc, p);
        e1 = exp_q.pop_front();
        tests_run++;
        if (p !== e1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got %h, required %h", p, e1);
        end
        sm8 = 1'b1; m8 = 8'hF9; q8 = 8'h06; start8 = 1'b1;
        exp_q.push_back(model(1'b1, 8, 32'hF9, 32'h06));
        @(posedge clk); #1;
        start8 = 1'b0;
        tests_run++;
        if (busy8 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accept: busy=%b, required 1", busy8);
        end
        held = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
            if (p8 !== e1[15:0]) held = 1'b0;
            if (i == 3) begin
                m8 = 8'h11; q8 = 8'h22; sm8 = 1'b0; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        e2 = exp_q.pop_front();
        tests_run++;
        if (!held) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold: product left %h before second done", e1[15:0]);
        end
        tests_run++;
        if (lat != 10 || p8 !== e2[15:0]) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: product=%h lat=%0d, required %h lat=10", p8, lat, e2[15:0]);
        end
        extra_done = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8 || busy8) extra_done++;
        end
        tests_run++;
        if (extra_done != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ignored_start: %0d busy/done cycles after op, required 0", extra_done);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat, bc, stray;
        logic [63:0] p, e;
        @(negedge clk);
        sm8 = 1'b0; m8 = 8'h0C; q8 = 8'h0B; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy8, done8, p8} !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset: busy=%b done=%b product=%h, required 0 0 0000", busy8, done8, p8);
        end
        reset = 1'b0; start8 = 1'b0;
        stray = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8 || busy8) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_discard: %0d busy/done cycles, required 0", stray);
        end
        run_op(8, 1'b0, 32'h0C, 32'h0B, lat, bc, p);
        e = exp_q.pop_front();
        tests_run++;
        if (p !== e || lat != 10) begin
            tests_failed++;
            $display("[TB] FAIL midreset_rerun: product=%h lat=%0d, required %h lat=10", p, lat, e);
        end
    endtask

    task automatic test_width4;
        int lat, bc;
        logic [63:0] p, e;
        run_op(4, 1'b1, 32'h8, 32'h7, lat, bc, p);
        e = exp_q.pop_front();
        tests_run++;
        if (p !== e || lat != 6) begin
            tests_failed++;
            $display("[TB] FAIL w4_signed: product=%h lat=%0d, required %h lat=6", p, lat, e);
        end
        run_op(4, 1'b0, 32'hF, 32'hF, lat, bc, p);
        e = exp_q.pop_front();
        tests_run++;
        if (p !== e || lat != 6) begin
            tests_failed++;
            $display("[TB] FAIL w4_unsigned: product=%h lat=%0d, required %h lat=6", p, lat, e);
        end
    endtask

    task automatic test_random(input int w, input int n);
        int lat, bc, want_lat;
        logic [63:0] p, e;
        logic [31:0] rm, rq;
        logic rs;
        want_lat = w + 2;
        for (int i = 0; i < n; i++) begin
            rm = $urandom;
            rq = $urandom;
            rs = 1'($urandom_range(1, 0));
            run_op(w, rs, rm, rq, lat, bc, p);
            e = exp_q.pop_front();
            tests_run++;
            if (p !== e || lat != want_lat) begin
                tests_failed++;
                $display("[TB] FAIL rand_w%0d_%0d: sm=%b m=%h q=%h product=%h lat=%0d, required %h lat=%0d",
                         w, i, rs, rm, rq, p, lat, e, want_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_corners();
        test_back_to_back();
        test_reset_mid_op();
        test_width4();
        test_random(8, 1000);
        test_random(4, 1000);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
